// File: rtl/ppu_bg_tile_fetcher_pkg.sv
// ppu_bg_tile_fetcher_pkg: nametable/attribute defaults, fetch phase encodings and loopy-v field positions
package ppu_bg_tile_fetcher_pkg;

    localparam logic [13:0] NT_BASE_DEFAULT   = 14'h2000;
    localparam logic [9:0]  AT_OFFSET_DEFAULT = 10'h3C0;

    typedef enum logic [1:0] {
        FETCH_NT    = 2'd0,
        FETCH_AT    = 2'd1,
        FETCH_PT_LO = 2'd2,
        FETCH_PT_HI = 2'd3
    } fetch_e;

    localparam int V_FINE_Y_LSB   = 12;
    localparam int V_NT_LSB       = 10;
    localparam int V_COARSE_Y_LSB = 5;
    localparam int V_COARSE_X_LSB = 0;

endpackage

// File: rtl/ppu_bg_tile_fetcher.sv
// ppu_bg_tile_fetcher: 8-dot NT/AT/PT-lo/PT-hi background fetch sequencer feeding the BG shifters
// Optional feature: define PPU_BG_FETCH_DEBUG_EN to expose o_debug_phase and o_debug_tile.
module ppu_bg_tile_fetcher
    import ppu_bg_tile_fetcher_pkg::*;
#(
    parameter logic [13:0] NT_BASE   = NT_BASE_DEFAULT,
    parameter logic [9:0]  AT_OFFSET = AT_OFFSET_DEFAULT
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_ce,
    input  logic        i_render_en,
    input  logic        i_fetch_active,
    input  logic [14:0] i_v,
    input  logic        i_pt_sel,
    output logic [13:0] o_vram_addr,
    output logic        o_vram_rd,
    input  logic [7:0]  i_vram_data,
    output logic        o_load,
    output logic [7:0]  o_pattern_lo,
    output logic [7:0]  o_pattern_hi,
    output logic [7:0]  o_attr_lo,
    output logic [7:0]  o_attr_hi,
`ifdef PPU_BG_FETCH_DEBUG_EN
    output logic [2:0]  o_debug_phase,
    output logic [7:0]  o_debug_tile,
`endif
    output logic        o_inc_coarse_x
);

    logic [2:0]  phase, phase_nx;
    logic [7:0]  tile, pt_lo;
    logic [1:0]  attr;
    logic        have_tile, run;
    fetch_e      fetch;
    logic [13:0] nt_addr, at_addr, pt_addr;

    // Picks the 2-bit palette of this tile's 16x16 quadrant out of the attribute byte
    function automatic logic [1:0] attr_quadrant(input logic [7:0] data, input logic q_y, input logic q_x);
        logic [7:0] s;
        s = data >> {q_y, q_x, 1'b0};
        return s[1:0];
    endfunction

    // Phase decode, VRAM address mux and the live strobes of the current phase
    always_comb begin
        run            = i_reset_n && i_render_en && i_fetch_active;
        fetch          = fetch_e'(phase[2:1]);
        phase_nx       = run ? phase + 3'd1 : 3'd0;
        nt_addr        = NT_BASE | {2'b00, i_v[11:0]};
        at_addr        = NT_BASE | {2'b00, i_v[V_NT_LSB +: 2], AT_OFFSET}
                                 | {8'h00, i_v[V_COARSE_Y_LSB+2 +: 3], 3'b000}
                                 | {11'h000, i_v[V_COARSE_X_LSB+2 +: 3]};
        pt_addr        = {1'b0, i_pt_sel, tile, fetch == FETCH_PT_HI, i_v[V_FINE_Y_LSB +: 3]};
        o_vram_addr    = !run ? 14'h0000 : fetch == FETCH_NT ? nt_addr : fetch == FETCH_AT ? at_addr : pt_addr;
        o_vram_rd      = run && phase[0];
        o_inc_coarse_x = run && phase == 3'd7;
    end

    // Phase counter, per-access data latches and the tile handed to the shifters on load
    always_ff @(negedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            phase        <= '0;
            tile         <= '0;
            attr         <= '0;
            pt_lo        <= '0;
            have_tile    <= 1'b0;
            o_pattern_lo <= '0;
            o_pattern_hi <= '0;
            o_attr_lo    <= '0;
            o_attr_hi    <= '0;
        end else if (i_ce) begin
            phase     <= phase_nx;
            have_tile <= o_inc_coarse_x;
            if (run && phase == 3'd1) tile <= i_vram_data;
            if (run && phase == 3'd3) attr <= attr_quadrant(i_vram_data, i_v[V_COARSE_Y_LSB+1], i_v[V_COARSE_X_LSB+1]);
            if (run && phase == 3'd5) pt_lo <= i_vram_data;
            if (o_inc_coarse_x) begin
                o_pattern_lo <= pt_lo;
                o_pattern_hi <= i_vram_data;
                o_attr_lo    <= {8{attr[0]}};
                o_attr_hi    <= {8{attr[1]}};
            end
        end
    end

    assign o_load = have_tile;

`ifdef PPU_BG_FETCH_DEBUG_EN
    assign o_debug_phase = phase;
    assign o_debug_tile  = tile;
`endif

endmodule

// File: tb/tb_ppu_bg_tile_fetcher.sv
// tb_ppu_bg_tile_fetcher: randomized group-level checking of the BG tile fetcher against an address/byte model
module tb_ppu_bg_tile_fetcher;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ce = 1'b1;
    logic        render_en = 1'b1;
    logic        fetch_active = 1'b1;
    logic        pt_sel = 1'b0;
    logic [14:0] v = '0;
    logic [7:0]  vram_data = '0;
    logic [13:0] vram_addr;
    logic        vram_rd, load, inc;
    logic [7:0]  plo, phi, alo, ahi;

    int          errors = 0;
    int          checks = 0;
    logic        load_due = 1'b0;
    logic [31:0] exp_bytes = '0;
    logic [14:0] cur_v = '0;
    logic        cur_sel = 1'b0;

    ppu_bg_tile_fetcher dut (
        .i_clk          (clk),
        .i_reset_n      (rst_n),
        .i_ce           (ce),
        .i_render_en    (render_en),
        .i_fetch_active (fetch_active),
        .i_v            (v),
        .i_pt_sel       (pt_sel),
        .o_vram_addr    (vram_addr),
        .o_vram_rd      (vram_rd),
        .i_vram_data    (vram_data),
        .o_load         (load),
        .o_pattern_lo   (plo),
        .o_pattern_hi   (phi),
        .o_attr_lo      (alo),
        .o_attr_hi      (ahi),
        .o_inc_coarse_x (inc)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Expected VRAM address of access k (0..7) of a group, from the documented address rules
    function automatic logic [13:0] ref_addr(input int k, input logic [14:0] vv, input logic sel, input logic [7:0] tile);
        int vi, a;
        vi = int'(vv);
        if (k / 2 == 0)
            a = 'h2000 + vi % 4096;
        else if (k / 2 == 1)
            a = 'h2000 + ((vi >> 10) % 4) * 1024 + 'h3C0 + ((vi >> 7) % 8) * 8 + (vi >> 2) % 8;
        else
            a = int'(sel) * 4096 + int'(tile) * 16 + (k / 2 == 3 ? 8 : 0) + (vi >> 12) % 8;
        return a[13:0];
    endfunction

    // One fetch dot, optionally preceded by i_ce-low stall cycles that must show identical outputs
    task automatic fetch_dot(input logic fa, input logic re, input logic [7:0] data, input logic [13:0] ea,
                             input logic erd, input logic einc, input int stall);
        int n;
        if (stall < 0) n = int'($urandom_range(0, 2));
        else n = stall;
        for (int s = 0; s <= n; s++) begin
            @(posedge clk);
            ce = (s == n);
            fetch_active = fa;
            render_en = re;
            v = cur_v;
            pt_sel = cur_sel;
            vram_data = data;
            #1;
            check("bus{addr,rd,inc,load}", {15'd0, vram_addr, vram_rd, inc, load}, {15'd0, ea, erd, einc, load_due});
            check("bytes{plo,phi,alo,ahi}", {plo, phi, alo, ahi}, exp_bytes);
        end
    endtask

    task automatic idle_dot(input int stall);
        fetch_dot(1'b0, 1'b1, 8'($urandom), 14'h0000, 1'b0, 1'b0, stall);
        load_due = 1'b0;
    endtask

    // One 8-dot group; cut_at<8 interrupts it (kind 0 window exit, 1 render off, 2 reset)
    task automatic fetch_group(input logic [14:0] vv, input logic sel, input logic [7:0] nt, input logic [7:0] at,
                               input logic [7:0] lo, input logic [7:0] hi, input int cut_at, input int cut_kind,
                               input int stall);
        logic [7:0] d [8];
        logic       cut;
        int         sh, ab;
        for (int k = 0; k < 8; k++) d[k] = 8'($urandom);
        d[1] = nt;
        d[3] = at;
        d[5] = lo;
        d[7] = hi;
        cur_v = vv;
        cur_sel = sel;
        cut = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (!cut && k == cut_at) begin
                cut = 1'b1;
                if (cut_kind == 2) begin
                    @(posedge clk);
                    ce = 1'b1;
                    fetch_active = 1'b1;
                    render_en = 1'b1;
                    v = cur_v;
                    pt_sel = cur_sel;
                    vram_data = d[k];
                    #1;
                    rst_n = 1'b0;
                    #1;
                    check("reset_mid_bus", {15'd0, vram_addr, vram_rd, inc, load}, 32'd0);
                    check("reset_mid_bytes", {plo, phi, alo, ahi}, 32'd0);
                    ce = 1'b0;
                    #1;
                    rst_n = 1'b1;
                    exp_bytes = '0;
                end else begin
                    fetch_dot(cut_kind != 0, cut_kind != 1, d[k], 14'h0000, 1'b0, 1'b0, stall);
                end
                load_due = 1'b0;
            end else if (!cut) begin
                fetch_dot(1'b1, 1'b1, d[k], ref_addr(k, vv, sel, nt), k % 2 == 1, k == 7, stall);
                load_due = 1'b0;
            end
        end
        if (!cut) begin
            sh = ((int'(vv) >> 6) & 1) * 4 + ((int'(vv) >> 1) & 1) * 2;
            ab = (int'(at) >> sh) & 3;
            exp_bytes = {lo, hi, (ab & 1) != 0 ? 8'hFF : 8'h00, (ab & 2) != 0 ? 8'hFF : 8'h00};
            load_due = 1'b1;
        end
    endtask

    initial begin
        #2;
        check("reset_bus", {15'd0, vram_addr, vram_rd, inc, load}, 32'd0);
        check("reset_bytes", {plo, phi, alo, ahi}, 32'd0);
        fetch_active = 1'b0;
        #1;
        rst_n = 1'b1;
        fetch_group(15'h0000, 1'b1, 8'h42, 8'h00, 8'h11, 8'h22, 8, 0, 0);
        fetch_group(15'h0002, 1'b0, 8'h17, 8'hE4, 8'hA5, 8'h3C, 8, 0, 0);
        idle_dot(0);
        check("end_of_window_bytes", {plo, phi, alo, ahi}, 32'hA53C_FF00);
        fetch_group(15'h1234, 1'b1, 8'h5A, 8'h9C, 8'h0F, 8'hF0, 4, 0, 0);
        idle_dot(0);
        fetch_group(15'h2345, 1'b0, 8'hC3, 8'h1B, 8'h66, 8'h99, 8, 0, 1);
        fetch_group(15'h4321, 1'b1, 8'h81, 8'h72, 8'h44, 8'h88, 6, 2, 0);
        fetch_group(15'h4321, 1'b1, 8'h81, 8'h72, 8'h44, 8'h88, 8, 0, 0);
        fetch_group(15'h7FFF, 1'b0, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 3, 1, 0);
        fetch_group(15'h7FFF, 1'b1, 8'hFF, 8'h1E, 8'h00, 8'hFF, 8, 0, 0);
        for (int i = 0; i < 60; i++) begin
            int cut_at, kind, stall;
            cut_at = ($urandom % 4 == 0) ? int'($urandom_range(1, 7)) : 8;
            kind = int'($urandom_range(0, 2));
            stall = ($urandom % 2 == 0) ? -1 : 0;
            fetch_group(15'($urandom), 1'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                        cut_at, kind, stall);
            if ($urandom % 3 == 0) idle_dot(stall);
        end
        idle_dot(0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
